led_frame_buffer: RTL and testbench
===================================

Name: led_frame_buffer

Overview:
Double-buffered pixel store that sits directly upstream of the WS2812B serial driver. A host writes per-LED RGB intensities into the back bank and issues a commit. The block then swaps banks and raises update_frame. It serves the driver's program_led_number lookups from the front bank, and detects the end of the frame to drop update_frame and enforce a low guard time before the next frame.

Parameters:
MAX_POS, 16, number of LEDs in the chain; must be >= 2; index width IW = $clog2(MAX_POS)
GUARD_CYCLES, 2700, minimum clk cycles update_frame stays low after a frame ends; must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write strobe into the back bank
wr_addr  input  IW  LED index to write
wr_red  input  8  red intensity
wr_green  input  8  green intensity
wr_blue  input  8  blue intensity
commit  input  1  single-cycle request to display the back bank
busy  output  1  high when state != IDLE or commit_pending
update_frame  output  1  frame request to the driver
led_index  input  IW  LED index requested by the driver (its program_led_number)
red_intensity  output  8  front-bank red for led_index
green_intensity  output  8  front-bank green for led_index
blue_intensity  output  8  front-bank blue for led_index
frame_done  output  1  one-cycle pulse at detected frame end

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: update_frame=0, frame_done=0, busy=0, all intensity outputs=0, bank_sel=0 (bank 0 is front), commit_pending=0, state=IDLE, guard_cnt=0, prev_index=0.
- Reset mid-operation: returns to the reset values on the next edge, regardless of state.
- RAM contents are not cleared by reset and are undefined until written.
- Storage: 2 banks x MAX_POS x 24 bits {green, red, blue}.
- Writes: when wr_en=1, the write goes to bank !bank_sel.
  - wr_addr >= MAX_POS: write ignored.
  - Writes are accepted in every state.
- Reads: outputs are registered, with 1-cycle latency from led_index.
  - Data comes from bank bank_sel.
  - led_index >= MAX_POS: all three outputs are 0.
  - Writes never alter the front bank.
- States:
  - IDLE: if commit=1, toggle bank_sel, set update_frame<=1, prev_index<=0, go to REQUEST.
    - A write in the same cycle lands in the old back bank, so it becomes part of the displayed frame.
  - REQUEST: update_frame held at 1. prev_index<=led_index every cycle.
    - Frame end is prev_index==MAX_POS-1 and led_index==0.
    - On frame end: update_frame<=0, frame_done<=1 for one cycle, guard_cnt<=0, go to GUARD.
  - GUARD: update_frame held at 0, guard_cnt increments.
    - When guard_cnt==GUARD_CYCLES-1: if commit_pending or commit=1, toggle bank_sel, clear commit_pending, update_frame<=1, go to REQUEST. Otherwise go to IDLE.
- Commit outside IDLE: a commit in REQUEST or GUARD sets commit_pending.
  - Further commits while pending merge into the one pending commit; no queueing.
  - The bank swap never occurs in REQUEST, so the front bank is stable for the whole frame.
- Guard timing: update_frame low time between frames is exactly GUARD_CYCLES cycles when a commit is pending.
- frame_done: never asserted outside the REQUEST->GUARD transition.
- Counters: guard_cnt width $clog2(GUARD_CYCLES); no wrap occurs.

Test Plan:
- Reset, write addr 3 = R0x12 G0x34 B0x56, commit -> update_frame=1 one cycle later; then led_index=3 -> next cycle red=0x12 green=0x34 blue=0x56; busy=1.
- In REQUEST, drive led_index 0..15 then 0 -> update_frame=0 and frame_done=1 on the same edge, one cycle wide; update_frame stays 0 for 2700 cycles; then IDLE with busy=0.
- Write addr 3 = 0xFF,0xFF,0xFF during REQUEST -> led_index=3 still reads 0x12/0x34/0x56; after the next commit and swap it reads 0xFF.
- Commit twice during REQUEST -> one pending commit; update_frame rises exactly 2700 cycles after frame_done; only one extra frame occurs.
- wr_addr=15 write accepted and readable; led_index=15 readback correct; with MAX_POS=12, wr_addr=13 is ignored and led_index=13 reads 0.
- Assert reset in REQUEST mid-frame -> next cycle update_frame=0, busy=0, outputs=0, bank_sel=0; a later commit starts a clean frame.

Source files
------------

// File: rtl/led_frame_buffer.sv
// Double-buffered RGB store for a WS2812B driver.
// Bank swap on commit, frame-end detection and inter-frame guard.
module led_frame_buffer #(
  parameter int MAX_POS = 16,
  parameter int GUARD_CYCLES = 2700,
  localparam int IW = $clog2(MAX_POS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [7:0]    wr_red,
  input  logic [7:0]    wr_green,
  input  logic [7:0]    wr_blue,
  input  logic          commit,
  output logic          busy,
  output logic          update_frame,
  input  logic [IW-1:0] led_index,
  output logic [7:0]    red_intensity,
  output logic [7:0]    green_intensity,
  output logic [7:0]    blue_intensity,
  output logic          frame_done
);

  localparam int GW = $clog2(GUARD_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(MAX_POS - 1);
  localparam logic [GW-1:0] GLAST = GW'(GUARD_CYCLES - 1);
  localparam logic [IW:0] LIMIT = (IW + 1)'(MAX_POS);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    GUARD
  } state_t;

  state_t state, state_n;
  logic bank_sel, bank_n;
  logic pend, pend_n;
  logic upd_n, done_n;
  logic [GW-1:0] guard_cnt, gcnt_n;
  logic [IW-1:0] prev_index, prev_n;

  logic [23:0] mem [2][MAX_POS];
  logic wr_ok, rd_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < LIMIT);
  assign rd_ok = {1'b0, led_index} < LIMIT;
  assign busy = (state != IDLE) || pend;

  // Writes always target the back bank, so the front bank is never disturbed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[~bank_sel][wr_addr] <= {wr_green, wr_red, wr_blue};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {green_intensity, red_intensity, blue_intensity} <= '0;
    end else if (rd_ok) begin
      {green_intensity, red_intensity, blue_intensity} <=
        mem[bank_sel][led_index];
    end else begin
      {green_intensity, red_intensity, blue_intensity} <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bank_sel <= 1'b0;
      pend <= 1'b0;
      update_frame <= 1'b0;
      frame_done <= 1'b0;
      guard_cnt <= '0;
      prev_index <= '0;
    end else begin
      state <= state_n;
      bank_sel <= bank_n;
      pend <= pend_n;
      update_frame <= upd_n;
      frame_done <= done_n;
      guard_cnt <= gcnt_n;
      prev_index <= prev_n;
    end
  end

  always_comb begin
    state_n = state;
    bank_n = bank_sel;
    pend_n = pend;
    upd_n = update_frame;
    done_n = 1'b0;
    gcnt_n = guard_cnt;
    prev_n = prev_index;
    unique case (state)
      IDLE: begin
        if (commit) begin
          bank_n = ~bank_sel;
          upd_n = 1'b1;
          prev_n = '0;
          state_n = REQUEST;
        end
      end
      REQUEST: begin
        prev_n = led_index;
        if (commit) pend_n = 1'b1;
        if (prev_index == LAST && led_index == '0) begin
          upd_n = 1'b0;
          done_n = 1'b1;
          gcnt_n = '0;
          state_n = GUARD;
        end
      end
      GUARD: begin
        gcnt_n = guard_cnt + 1'b1;
        if (commit) pend_n = 1'b1;
        if (guard_cnt == GLAST) begin
          if (pend || commit) begin
            bank_n = ~bank_sel;
            pend_n = 1'b0;
            upd_n = 1'b1;
            prev_n = '0;
            state_n = REQUEST;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Bench for led_frame_buffer: directed literal checks plus
// randomized traffic compared every cycle against an event-level model.
module tb_led_frame_buffer;
  localparam int MAX_POS = 12;
  localparam int GUARD = 2700;
  localparam int IW = $clog2(MAX_POS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [7:0] wr_red = '0, wr_green = '0, wr_blue = '0;
  logic commit = 1'b0;
  logic busy, update_frame, frame_done;
  logic [IW-1:0] led_index = '0;
  logic [7:0] red_intensity, green_intensity, blue_intensity;

  int checks = 0;
  int failures = 0;

  led_frame_buffer #(.MAX_POS(MAX_POS), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_red(wr_red),
    .wr_green(wr_green),
    .wr_blue(wr_blue),
    .commit(commit),
    .busy(busy),
    .update_frame(update_frame),
    .led_index(led_index),
    .red_intensity(red_intensity),
    .green_intensity(green_intensity),
    .blue_intensity(blue_intensity),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Event-level model: which bank is shown, whether a frame is on
  // the wire, how much guard time remains, and one pending flag.
  logic [23:0] pix [2][MAX_POS];
  bit known [2][MAX_POS];
  int front = 0;
  bit in_frame = 0, in_guard = 0, pending = 0;
  int guard_left = 0;
  int last_idx = 0;
  bit m_upd = 0, m_done = 0, m_known = 1, m_valid = 0;
  logic [23:0] m_rgb = '0;

  always @(posedge clk) begin
    if (reset) begin
      front = 0; in_frame = 0; in_guard = 0; pending = 0;
      last_idx = 0; m_upd = 0; m_done = 0;
      m_rgb = '0; m_known = 1; m_valid = 1;
    end else begin
      if (int'(led_index) >= MAX_POS) begin
        m_rgb = '0; m_known = 1;
      end else begin
        m_rgb = pix[front][led_index];
        m_known = known[front][led_index];
      end
      if (wr_en && int'(wr_addr) < MAX_POS) begin
        pix[1-front][wr_addr] = {wr_green, wr_red, wr_blue};
        known[1-front][wr_addr] = 1;
      end
      m_done = 0;
      if (in_frame) begin
        if (commit) pending = 1;
        if (last_idx == MAX_POS - 1 && led_index == 0) begin
          in_frame = 0; in_guard = 1; guard_left = GUARD;
          m_upd = 0; m_done = 1;
        end
        last_idx = int'(led_index);
      end else if (in_guard) begin
        if (commit) pending = 1;
        guard_left--;
        if (guard_left == 0) begin
          in_guard = 0;
          if (pending) begin
            pending = 0; front = 1 - front;
            in_frame = 1; m_upd = 1; last_idx = 0;
          end
        end
      end else if (commit) begin
        front = 1 - front; in_frame = 1; m_upd = 1; last_idx = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_update", 32'(update_frame), 32'(m_upd));
      chk("m_done", 32'(frame_done), 32'(m_done));
      chk("m_busy", 32'(busy), 32'(in_frame || in_guard || pending));
      if (m_known)
        chk("m_rgb", 32'({green_intensity, red_intensity, blue_intensity}),
            32'(m_rgb));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [23:0] grb);
    wr_en = 1; wr_addr = IW'(a);
    {wr_green, wr_red, wr_blue} = grb;
    cyc();
    wr_en = 0;
  endtask

  task automatic pulse_commit();
    commit = 1; cyc(); commit = 0;
  endtask

  task automatic sweep();
    for (int i = 0; i < MAX_POS; i++) begin
      led_index = IW'(i); cyc();
    end
    led_index = '0; cyc();
  endtask

  int n;
  int seq;

  initial begin
    cyc(); cyc();
    reset = 0;
    @(negedge clk);
    chk("rst_update", 32'(update_frame), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_red", 32'(red_intensity), 0);
    chk("rst_done", 32'(frame_done), 0);

    wr(3, 24'h341256);
    pulse_commit();
    chk("commit_update", 32'(update_frame), 1);
    chk("commit_busy", 32'(busy), 1);
    led_index = 3; cyc();
    chk("rd_red", 32'(red_intensity), 32'h12);
    chk("rd_green", 32'(green_intensity), 32'h34);
    chk("rd_blue", 32'(blue_intensity), 32'h56);

    wr(3, 24'hFFFFFF);
    cyc();
    chk("front_stable", 32'(red_intensity), 32'h12);
    pulse_commit();
    pulse_commit();
    chk("pend_busy", 32'(busy), 1);
    chk("no_swap_req", 32'(red_intensity), 32'h12);

    sweep();
    chk("end_done", 32'(frame_done), 1);
    chk("end_update", 32'(update_frame), 0);
    cyc();
    chk("done_width", 32'(frame_done), 0);
    n = 1;
    while (!update_frame && n < 5000) begin cyc(); n++; end
    chk("guard_len", 32'(n), GUARD);
    led_index = 3; cyc();
    chk("swap_red", 32'(red_intensity), 32'hFF);

    sweep();
    chk("end2_done", 32'(frame_done), 1);
    n = 0;
    while (busy && n < 5000) begin cyc(); n++; end
    chk("idle_len", 32'(n), GUARD);
    chk("idle_update", 32'(update_frame), 0);

    wr(11, 24'hB2A1C3);
    wr(13, 24'h777777);
    pulse_commit();
    led_index = 11; cyc();
    chk("last_red", 32'(red_intensity), 32'hA1);
    chk("last_green", 32'(green_intensity), 32'hB2);
    led_index = 13; cyc();
    chk("oob_rgb", 32'({green_intensity, red_intensity, blue_intensity}), 0);

    led_index = 5; cyc();
    reset = 1; cyc();
    chk("mid_rst_update", 32'(update_frame), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_red", 32'(red_intensity), 0);
    reset = 0;
    pulse_commit();
    chk("clean_update", 32'(update_frame), 1);
    led_index = 3; cyc();
    chk("clean_red", 32'(red_intensity), 32'h12);

    seq = 0;
    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom % 6000 == 0);
      wr_en = !reset && ($urandom % 3 == 0);
      wr_addr = IW'($urandom % 16);
      {wr_green, wr_red, wr_blue} = 24'($urandom);
      commit = ($urandom % 150 == 0);
      if ($urandom % 10 == 0) begin
        led_index = IW'($urandom % 16);
      end else begin
        led_index = IW'(seq);
        seq = (seq + 1) % MAX_POS;
      end
      cyc();
    end
    reset = 0; wr_en = 0; commit = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
